// File: rtl/simple_3.sv
// simple_3: registered 4-bit conditional inverter with an up/down accumulator.
// D=1 passes A and adds it to the accumulator. D=0 inverts A and subtracts it.
// Both outputs are registered, so each one reflects the inputs sampled at the
// previous rising edge. Arithmetic wraps modulo 16 with no carry or borrow.
module simple_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic       D,
    output logic [3:0] B,
    output logic [3:0] E
);

    logic [3:0] b_q, b_d;
    logic [3:0] e_q, e_d;

    // Next-state: conditional invert and add/subtract, both truncated to 4 bits
    always_comb begin
        b_d = A;
        e_d = e_q;
        if (D) begin
            b_d = A;
            e_d = e_q + A;
        end else begin
            b_d = ~A;
            e_d = e_q - A;
        end
    end

    // State registers; synchronous reset overrides every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q <= 4'h0;
            e_q <= 4'h0;
        end else begin
            b_q <= b_d;
            e_q <= e_d;
        end
    end

    assign B = b_q;
    assign E = e_q;

endmodule

// File: tb/tb_simple_3.sv
// Scoreboard bench for simple_3: stimulus pushes expected outputs into a
// queue, a separate monitor pops and compares one entry after every edge.
module tb_simple_3;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic       D;
    logic [3:0] B;
    logic [3:0] E;

    typedef struct {
        logic [3:0] b;
        logic [3:0] e;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [3:0] m_e;

    simple_3 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .D   (D),
        .B   (B),
        .E   (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector on the falling edge and queue the outputs it should produce
    task automatic issue(input logic r, input logic [3:0] a, input logic d,
                         input logic [3:0] eb, input logic [3:0] ee, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r;
        A   = a;
        D   = d;
        x.b = eb;
        x.e = ee;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: sample just after each rising edge, compare against the queue head
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                n_total++;
                if (B === x.b && E === x.e) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got B=%h E=%h, expected B=%h E=%h",
                             x.name, B, E, x.b, x.e);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] v;
        logic [3:0] mb;
        rst = 1'b1;
        A   = 4'h0;
        D   = 1'b0;

        // Reset held two cycles with active-looking inputs
        issue(1'b1, 4'hF, 1'b1, 4'h0, 4'h0, "reset_c1");
        issue(1'b1, 4'hF, 1'b1, 4'h0, 4'h0, "reset_c2");

        // Pass/add
        issue(1'b0, 4'h3, 1'b1, 4'h3, 4'h3, "add_3");
        issue(1'b0, 4'h4, 1'b1, 4'h4, 4'h7, "add_4");
        issue(1'b0, 4'h5, 1'b1, 4'h5, 4'hC, "add_5");

        // Invert/subtract
        issue(1'b0, 4'h5, 1'b0, 4'hA, 4'h7, "sub_5");

        // Reach E=E, then wrap up and down
        issue(1'b0, 4'h7, 1'b1, 4'h7, 4'hE, "add_7");
        issue(1'b0, 4'h3, 1'b1, 4'h3, 4'h1, "wrap_add");
        issue(1'b0, 4'h2, 1'b0, 4'hD, 4'hF, "wrap_sub");

        // A=0 leaves E unchanged in both modes
        issue(1'b0, 4'h0, 1'b1, 4'h0, 4'hF, "zero_add");
        issue(1'b0, 4'h0, 1'b0, 4'hF, 4'hF, "zero_sub");

        // E=1 + F wraps to 0; 0 - 1 wraps to F
        issue(1'b0, 4'hE, 1'b0, 4'h1, 4'h1, "set_e1");
        issue(1'b0, 4'hF, 1'b1, 4'hF, 4'h0, "boundary_add_f");
        issue(1'b0, 4'h1, 1'b0, 4'hE, 4'hF, "boundary_sub_1");

        // Clear before the sweep
        issue(1'b1, 4'h9, 1'b0, 4'h0, 4'h0, "reset_mid");

        // Exhaustive sweep against a reference model; final E is zero
        m_e = 4'h0;
        for (int i = 31; i >= 0; i--) begin
            v  = i[4:0];
            mb = v[4] ? v[3:0] : ~v[3:0];
            m_e = v[4] ? (m_e + v[3:0]) : (m_e - v[3:0]);
            if (i == 0) issue(1'b0, 4'h0, 1'b0, 4'hF, 4'h0, "sweep_final");
            else        issue(1'b0, v[3:0], v[4], mb, m_e, "sweep");
        end

        // Second sweep with a one-cycle reset in the middle
        issue(1'b1, 4'h0, 1'b0, 4'h0, 4'h0, "reset_pre_sweep2");
        m_e = 4'h0;
        for (int i = 31; i >= 0; i--) begin
            v = i[4:0];
            if (i == 20) begin
                m_e = 4'h0;
                issue(1'b1, v[3:0], v[4], 4'h0, 4'h0, "sweep2_reset");
            end else begin
                mb  = v[4] ? v[3:0] : ~v[3:0];
                m_e = v[4] ? (m_e + v[3:0]) : (m_e - v[3:0]);
                issue(1'b0, v[3:0], v[4], mb, m_e, "sweep2");
            end
        end

        // Drain the scoreboard
        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
